// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Words written on WrData/WrEn are queued in a circular FIFO and sent on Tx
// as start bit, DATA_BITS data bits (LSB first), optional parity bit and
// STOP_BITS stop bits, each bit lasting SYSCLK_RATE/BAUD_RATE clocks.
// Ports:
//   SysClk   - system clock, rising edge
//   Reset    - asynchronous active-high reset
//   WrData   - word to transmit
//   WrEn     - write strobe
//   Full     - FIFO holds 2**FIFO_WIDTH words
//   Empty    - FIFO holds no words
//   Count    - FIFO occupancy
//   Overflow - one-cycle pulse after a dropped write
//   Busy     - a frame is on the line
//   Tx       - serial output, idle high
module uart_tx_fifo #(
  parameter int unsigned SYSCLK_RATE = 9600000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 2,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned FIFO_WIDTH  = 4
) (
  input  logic                 SysClk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] WrData,
  input  logic                 WrEn,
  output logic                 Full,
  output logic                 Empty,
  output logic [FIFO_WIDTH:0]  Count,
  output logic                 Overflow,
  output logic                 Busy,
  output logic                 Tx
);

  localparam int unsigned BIT_CYCLES = SYSCLK_RATE / BAUD_RATE;
  localparam int unsigned CYC_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS + 1) : 1;
  localparam int unsigned CNT_W      = FIFO_WIDTH + 1;
  localparam int unsigned DEPTH      = 2 ** FIFO_WIDTH;

  // Reject unsupported configurations at elaboration.
  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_fifo: BIT_CYCLES must be at least 2");
  end
  if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 1..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1..2");
  end
  if (PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0..2");
  end
  if (FIFO_WIDTH < 1 || FIFO_WIDTH > 8) begin : g_bad_fifo
    $error("uart_tx_fifo: FIFO_WIDTH must be 1..8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]  mem_q [DEPTH];

  logic                  wr_acc;
  logic                  pop;
  logic                  bit_end;
  logic [DATA_BITS-1:0]  head;

  // FIFO bookkeeping, frame sequencing and registered line outputs.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    pop        = 1'b0;
    head       = mem_q[rd_ptr_q];
    // Registered Full gates writes, so a same-cycle pop cannot rescue a write.
    wr_acc     = WrEn && !full_q;
    bit_end    = (cyc_q == CYC_W'(BIT_CYCLES - 1));

    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + CYC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!empty_q) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when more data is queued.
            if (!empty_q) pop = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Parity is latched with the word so the shift register can be consumed.
    if (pop) begin
      state_d = S_START;
      cyc_d   = '0;
      shift_d = head;
      par_d   = (^head) ^ (PARITY_MODE == 2);
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);

    ovf_d    = WrEn && full_q;
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    wr_ptr_d = wr_acc ? wr_ptr_q + FIFO_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + FIFO_WIDTH'(1) : rd_ptr_q;
  end

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge SysClk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= WrData;
  end

  assign Tx       = tx_q;
  assign Busy     = busy_q;
  assign Overflow = ovf_q;
  assign Full     = full_q;
  assign Empty    = empty_q;
  assign Count    = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (even, odd, no parity) at
// BIT_CYCLES=8, DATA_BITS=8, STOP_BITS=2, FIFO_WIDTH=2.
module tb_uart_tx_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en   [3];
  logic [DW-1:0] wr_data [3];
  logic          full    [3];
  logic          empty   [3];
  logic          ovf     [3];
  logic          busy    [3];
  logic          tx      [3];
  logic [CW-1:0] count   [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_bits [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.SYSCLK_RATE(80), .BAUD_RATE(10), .DATA_BITS(8), .STOP_BITS(2),
                 .PARITY_MODE(1), .FIFO_WIDTH(2)) u_even (
    .SysClk(clk), .Reset(rst), .WrData(wr_data[0]), .WrEn(wr_en[0]),
    .Full(full[0]), .Empty(empty[0]), .Count(count[0]), .Overflow(ovf[0]),
    .Busy(busy[0]), .Tx(tx[0]));

  uart_tx_fifo #(.SYSCLK_RATE(80), .BAUD_RATE(10), .DATA_BITS(8), .STOP_BITS(2),
                 .PARITY_MODE(2), .FIFO_WIDTH(2)) u_odd (
    .SysClk(clk), .Reset(rst), .WrData(wr_data[1]), .WrEn(wr_en[1]),
    .Full(full[1]), .Empty(empty[1]), .Count(count[1]), .Overflow(ovf[1]),
    .Busy(busy[1]), .Tx(tx[1]));

  uart_tx_fifo #(.SYSCLK_RATE(80), .BAUD_RATE(10), .DATA_BITS(8), .STOP_BITS(2),
                 .PARITY_MODE(0), .FIFO_WIDTH(2)) u_none (
    .SysClk(clk), .Reset(rst), .WrData(wr_data[2]), .WrEn(wr_en[2]),
    .Full(full[2]), .Empty(empty[2]), .Count(count[2]), .Overflow(ovf[2]),
    .Busy(busy[2]), .Tx(tx[2]));

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [11:0] bits;   // transmission order, first bit at [nbits-1]
    int         nbits;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame builder used by the multi-frame sequences.
  task automatic push_frame(input logic [7:0] d, input int mode);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (mode != 0) exp_bits.push_back((^d) ^ (mode == 2));
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
  endtask

  // Call between the negedge before the pop edge and the pop edge itself.
  task automatic check_stream(input int sel, input string tag);
    int   busy_hi;
    logic ok;
    logic got;
    busy_hi = 0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      ok  = 1'b1;
      got = exp_bits[b];
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (busy[sel] === 1'b1) busy_hi++;
        if (ok && (tx[sel] !== exp_bits[b])) begin
          ok  = 1'b0;
          got = tx[sel];
        end
      end
      chk($sformatf("%s bit%0d", tag, b), 32'(got), 32'(exp_bits[b]));
    end
    chk($sformatf("%s busy_cycles", tag), 32'(busy_hi), 32'(exp_bits.size() * 8));
  endtask

  task automatic send_one(input int sel, input logic [7:0] d, input string tag);
    @(negedge clk);
    wr_en[sel]   = 1'b1;
    wr_data[sel] = d;
    @(posedge clk);
    @(negedge clk);
    wr_en[sel] = 1'b0;
    chk({tag, " tx_before_pop"}, 32'(tx[sel]), 32'd1);
    chk({tag, " busy_before_pop"}, 32'(busy[sel]), 32'd0);
    chk({tag, " count_after_write"}, 32'(count[sel]), 32'd1);
    chk({tag, " empty_after_write"}, 32'(empty[sel]), 32'd0);
    check_stream(sel, tag);
    @(negedge clk);
    chk({tag, " tx_idle_after"}, 32'(tx[sel]), 32'd1);
    chk({tag, " busy_idle_after"}, 32'(busy[sel]), 32'd0);
    chk({tag, " empty_after"}, 32'(empty[sel]), 32'd1);
  endtask

  initial begin
    logic [7:0] w [6];
    int         exp_cnt [6];
    int         bad_tx, bad_busy, bad_cnt;

    vecs[0] = '{sel: 0, data: 8'hA5, bits: 12'b010100101011, nbits: 12};
    vecs[1] = '{sel: 1, data: 8'hA5, bits: 12'b010100101111, nbits: 12};
    vecs[2] = '{sel: 2, data: 8'hA5, bits: 12'b001010010111, nbits: 11};
    vecs[3] = '{sel: 0, data: 8'hFF, bits: 12'b011111111011, nbits: 12};

    for (int i = 0; i < 3; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = '0;
    end

    // Power-on reset values.
    rst = 1'b1;
    #2;
    chk("rst tx", 32'(tx[0]), 32'd1);
    chk("rst busy", 32'(busy[0]), 32'd0);
    chk("rst empty", 32'(empty[0]), 32'd1);
    chk("rst full", 32'(full[0]), 32'd0);
    chk("rst count", 32'(count[0]), 32'd0);
    chk("rst ovf", 32'(ovf[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames across the three parity configurations.
    for (int v = 0; v < 4; v++) begin
      exp_bits.delete();
      for (int i = 0; i < vecs[v].nbits; i++)
        exp_bits.push_back(vecs[v].bits[vecs[v].nbits - 1 - i]);
      send_one(vecs[v].sel, vecs[v].data, $sformatf("vec%0d", v));
      repeat (3) @(negedge clk);
    end

    // Back-to-back: second start bit follows the last stop cycle directly.
    exp_bits.delete();
    push_frame(8'h01, 1);
    push_frame(8'h02, 1);
    @(negedge clk);
    wr_en[0]   = 1'b1;
    wr_data[0] = 8'h01;
    @(posedge clk);
    @(negedge clk);
    wr_data[0] = 8'h02;
    chk("b2b count1", 32'(count[0]), 32'd1);
    fork
      check_stream(0, "b2b");
      begin
        @(negedge clk);
        wr_en[0] = 1'b0;
        chk("b2b count_write_and_pop", 32'(count[0]), 32'd1);
      end
    join
    @(negedge clk);
    chk("b2b tx_idle", 32'(tx[0]), 32'd1);
    chk("b2b busy_idle", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);

    // Overflow: six writes from idle, sixth dropped, first five sent in order.
    w       = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    exp_bits.delete();
    for (int k = 0; k < 5; k++) push_frame(w[k], 1);
    @(negedge clk);
    wr_en[0]   = 1'b1;
    wr_data[0] = w[0];
    @(posedge clk);
    @(negedge clk);
    chk("ovf count0", 32'(count[0]), 32'd1);
    chk("ovf pulse0", 32'(ovf[0]), 32'd0);
    fork
      check_stream(0, "ovf_stream");
      begin
        for (int k = 1; k < 6; k++) begin
          wr_data[0] = w[k];
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("ovf count%0d", k), 32'(count[0]), 32'(exp_cnt[k]));
          chk($sformatf("ovf pulse%0d", k), 32'(ovf[0]), 32'(k == 5));
          chk($sformatf("ovf full%0d", k), 32'(full[0]), 32'(k >= 4));
        end
        wr_en[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ovf pulse_end", 32'(ovf[0]), 32'd0);
        chk("ovf count_hold", 32'(count[0]), 32'd4);
      end
    join
    @(negedge clk);
    chk("ovf tx_idle", 32'(tx[0]), 32'd1);
    chk("ovf empty_end", 32'(empty[0]), 32'd1);
    repeat (3) @(negedge clk);

    // Reset mid-frame with three words still queued.
    @(negedge clk);
    wr_en[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_data[0] = 8'h31 + 8'(k);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("mid count%0d", k), 32'(count[0]), 32'(exp_cnt[k]));
    end
    wr_en[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid busy_in_data", 32'(busy[0]), 32'd1);
    chk("mid count_in_data", 32'(count[0]), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid tx_async", 32'(tx[0]), 32'd1);
    chk("mid busy_async", 32'(busy[0]), 32'd0);
    chk("mid count_async", 32'(count[0]), 32'd0);
    chk("mid empty_async", 32'(empty[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bad_tx = 0; bad_busy = 0; bad_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) bad_tx++;
      if (busy[0] !== 1'b0) bad_busy++;
      if (count[0] !== '0) bad_cnt++;
    end
    chk("mid quiet_tx", 32'(bad_tx), 32'd0);
    chk("mid quiet_busy", 32'(bad_busy), 32'd0);
    chk("mid quiet_count", 32'(bad_cnt), 32'd0);

    // After reset, a 0x00 frame still starts two edges after the write.
    exp_bits.delete();
    begin
      logic [11:0] z;
      z = 12'b000000000011;
      for (int i = 0; i < 12; i++) exp_bits.push_back(z[11 - i]);
    end
    send_one(0, 8'h00, "zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
